// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit with HI/LO registers; MADD (op 7) enabled by MDU_MADD_EN.
module e_mdu #(
  parameter int WIDTH = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MDUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);
  localparam int CMAX = MUL_CYCLES > DIV_CYCLES ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [0:0] IDLE = 1'b0, RUN = 1'b1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [0:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, shi_q, shi_d, slo_q, slo_d;
  logic               done_q, done_d;
  logic               is_mul, is_div, is_madd, sgn_mul, sgn_div;
  logic [2*WIDTH-1:0] ma, mb, mul_res;
  logic [WIDTH-1:0]   dn, dd, ddn, uq, ur, div_hi, div_lo;
  always_comb begin
`ifdef MDU_MADD_EN
    is_madd = MDUOp == 3'd7;
`else
    is_madd = 1'b0;
`endif
    is_mul  = MDUOp == 3'd1 || MDUOp == 3'd2 || is_madd;
    is_div  = MDUOp == 3'd3 || MDUOp == 3'd4;
    sgn_mul = MDUOp != 3'd2;
    sgn_div = MDUOp == 3'd3;
    ma = {{WIDTH{sgn_mul & A[WIDTH-1]}}, A};
    mb = {{WIDTH{sgn_mul & B[WIDTH-1]}}, B};
`ifdef MDU_MADD_EN
    mul_res = ma * mb + (is_madd ? {hi_q, lo_q} : '0);
`else
    mul_res = ma * mb;
`endif
    // signed divide runs on magnitudes; a zero divisor is masked so the divider never sees it
    dn  = (sgn_div && A[WIDTH-1]) ? -A : A;
    dd  = (sgn_div && B[WIDTH-1]) ? -B : B;
    ddn = dd == '0 ? ONE : dd;
    uq  = dn / ddn;
    ur  = dn % ddn;
    div_lo = B == '0 ? '1 : (sgn_div && (A[WIDTH-1] ^ B[WIDTH-1])) ? -uq : uq;
    div_hi = B == '0 ? A : (sgn_div && A[WIDTH-1]) ? -ur : ur;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    shi_d   = shi_q;
    slo_d   = slo_q;
    done_d  = 1'b0;
    if (state_q == IDLE && start) begin
      if (is_mul || is_div) begin
        state_d        = RUN;
        cnt_d          = is_mul ? CW'(MUL_CYCLES) : CW'(DIV_CYCLES);
        {shi_d, slo_d} = is_div ? {div_hi, div_lo} : mul_res;
      end
      hi_d = MDUOp == 3'd5 ? A : hi_q;
      lo_d = MDUOp == 3'd6 ? A : lo_q;
    end else if (state_q == RUN) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = IDLE;
        hi_d    = shi_q;
        lo_d    = slo_q;
        done_d  = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      shi_q   <= '0;
      slo_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      shi_q   <= shi_d;
      slo_q   <= slo_d;
      done_q  <= done_d;
    end
  end
  assign busy = state_q == RUN;
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed vectors for e_mdu; expected HI/LO queued at issue, checked on each done pulse.
module tb_e_mdu;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  MDUOp = 3'd0;
  logic [31:0] A = '0, B = '0;
  logic        busy, done;
  logic [31:0] HI, LO;
  logic [63:0] exp_q[$];
  logic [63:0] e;
  int          vecs = 0, errs = 0;

  e_mdu dut (.clk(clk), .reset(reset), .start(start), .MDUOp(MDUOp), .A(A), .B(B),
             .busy(busy), .done(done), .HI(HI), .LO(LO));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) begin
      vecs++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL unexpected_done got HI=%h LO=%h", HI, LO);
      end else begin
        e = exp_q.pop_front();
        if ({HI, LO} !== e) begin
          errs++;
          $display("FAIL result got %h_%h want %h_%h", HI, LO, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; MDUOp = op; A = a; B = b;
    @(negedge clk);
    start = 1'b0; MDUOp = 3'd0;
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [63:0] x, input int n);
    int cnt;
    exp_q.push_back(x);
    issue(op, a, b);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("busy_cycles", cnt, n);
  endtask

  initial begin
    #1;
    chk("rst_hi", HI, 0);
    chk("rst_lo", LO, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run(3'd1, 32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 5);
    run(3'd4, 32'd100, 32'd7, {32'd2, 32'd14}, 10);
    run(3'd3, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10);
    run(3'd3, 32'd5, 32'd0, {32'd5, 32'hFFFF_FFFF}, 10);
    run(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 10);
    issue(3'd5, 32'h1234, 32'd0);
    chk("mthi_busy_low", {31'd0, busy}, 0);
    issue(3'd6, 32'h5678, 32'd0);
    chk("mtlo_busy_low", {31'd0, busy}, 0);
    chk("mthi_hi", HI, 32'h1234);
    chk("mtlo_lo", LO, 32'h5678);
    issue(3'd0, 32'h9999, 32'h9999);
    chk("nop_busy", {31'd0, busy}, 0);
    chk("nop_hi", HI, 32'h1234);
    chk("nop_lo", LO, 32'h5678);
    exp_q.push_back({32'd0, 32'd6});
    issue(3'd1, 32'd2, 32'd3);
    chk("busy_after_issue", {31'd0, busy}, 1);
    issue(3'd5, 32'hDEAD, 32'd0);
    chk("mthi_ignored", HI, 32'h1234);
    chk("hi_hold_run", HI, 32'h1234);
    repeat (20) if (busy) @(negedge clk);
    chk("mult_idle", {31'd0, busy}, 0);
    issue(3'd2, 32'd5, 32'd5);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_hi", HI, 0);
    chk("midrst_lo", LO, 0);
    chk("midrst_busy", {31'd0, busy}, 0);
    @(negedge clk);
    reset = 1'b1;
    run(3'd2, 32'hFFFF_FFFF, 32'd2, {32'd1, 32'hFFFF_FFFE}, 5);
    issue(3'd5, 32'd0, 32'd0);
    issue(3'd6, 32'd10, 32'd0);
`ifdef MDU_MADD_EN
    run(3'd7, 32'd3, 32'd4, {32'd0, 32'd22}, 5);
`else
    issue(3'd7, 32'd3, 32'd4);
    chk("op7_busy", {31'd0, busy}, 0);
    repeat (6) @(negedge clk);
    chk("op7_hi", HI, 0);
    chk("op7_lo", LO, 32'd10);
`endif
    repeat (3) @(negedge clk);
    chk("pending", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
